// File: rtl/grid_burst_sequencer_if.sv
// Byte-stream side (ss/spi_done/spi_input) and register-bank/grid side of the
// burst sequencer, bundled so the host model and the sequencer share one port.
interface grid_burst_sequencer_if #(
  parameter int ID_W   = 3,
  parameter int DATA_W = 8
);
  logic              ss;
  logic              spi_done;
  logic [DATA_W-1:0] spi_input;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ID_W-1:0]   wr_id;
  logic [DATA_W-1:0] wr_data;
  logic              din_en;
  logic              trig;
  logic [ID_W-1:0]   out_sel;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output ss, spi_done, spi_input,
    input  wr_en, wr_sel, wr_id, wr_data, din_en, trig, out_sel, busy, done, err
  );
  modport slave (
    input  ss, spi_done, spi_input,
    output wr_en, wr_sel, wr_id, wr_data, din_en, trig, out_sel, busy, done, err
  );
endinterface

// File: rtl/grid_burst_sequencer.sv
// Header-driven sequencer: turns received bytes into per-neuron register writes,
// a din load followed by a timed trigger, and the readback neuron select.
module grid_burst_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int DATA_W    = 8,
  parameter int RUN_WAIT  = 4
) (
  input logic                   clk,
  input logic                   rst,
  grid_burst_sequencer_if.slave bus
);
  localparam int ID_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_NEURONS - 1);
  localparam logic [7:0]      WAIT_LAST = 8'(RUN_WAIT);

  typedef enum logic [2:0] {S_IDLE, S_BURST, S_DIN, S_TRIG, S_WAIT, S_DRAIN} state_t;
  typedef enum logic [1:0] {OP_BURST, OP_RUN, OP_SETOUT, OP_ILLEGAL} op_t;
  typedef struct packed {
    logic              en;
    logic [1:0]        sel;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] id, id_nx;
  logic [1:0]      field, field_nx;
  logic [7:0]      cnt, cnt_nx;
  wr_t             wr, wr_nx;
  logic            din_en, din_en_nx;
  logic            trig, trig_nx;
  logic [ID_W-1:0] out_sel, out_sel_nx;
  logic            err, err_nx;

  op_t             op;
  logic [1:0]      hfield;
  logic [ID_W-1:0] hid;
  logic            hdr_ok;

  assign op     = op_t'(bus.spi_input[7:6]);
  assign hfield = bus.spi_input[5:4];
  assign hid    = ID_W'(bus.spi_input[2:0]);
  assign hdr_ok = bus.spi_done & ~bus.ss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      id      <= '0;
      field   <= '0;
      cnt     <= '0;
      wr      <= '0;
      din_en  <= 1'b0;
      trig    <= 1'b0;
      out_sel <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      id      <= id_nx;
      field   <= field_nx;
      cnt     <= cnt_nx;
      wr      <= wr_nx;
      din_en  <= din_en_nx;
      trig    <= trig_nx;
      out_sel <= out_sel_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    id_nx      = id;
    field_nx   = field;
    cnt_nx     = cnt;
    wr_nx      = wr;
    wr_nx.en   = 1'b0;
    din_en_nx  = 1'b0;
    trig_nx    = 1'b0;
    out_sel_nx = out_sel;
    err_nx     = err;
    case (state)
      S_IDLE: if (hdr_ok) begin
        case (op)
          OP_BURST:
            if (hfield == 2'b11) begin
              err_nx   = 1'b1;
              state_nx = S_DRAIN;
            end else begin
              id_nx    = hid;
              field_nx = hfield;
              state_nx = S_BURST;
            end
          OP_RUN: begin
            out_sel_nx = hid;
            state_nx   = S_DIN;
          end
          OP_SETOUT: begin
            out_sel_nx = hid;
            if (hfield[1]) err_nx = 1'b0;
          end
          default: begin
            err_nx   = 1'b1;
            state_nx = S_DRAIN;
          end
        endcase
      end
      // ss wins over a coincident byte: the byte is dropped unwritten
      S_BURST:
        if (bus.ss) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.spi_done) begin
          wr_nx.en   = 1'b1;
          wr_nx.sel  = field;
          wr_nx.id   = (field == 2'b10) ? '0 : id;
          wr_nx.data = bus.spi_input;
          id_nx      = id + ID_W'(1);
          if (field == 2'b10 || id == LAST_ID) state_nx = S_IDLE;
        end
      S_DIN:
        if (bus.ss) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.spi_done) begin
          din_en_nx  = 1'b1;
          wr_nx.data = bus.spi_input;
          state_nx   = S_TRIG;
        end
      // din_en cycle; trig is registered so it lands one cycle later
      S_TRIG: begin
        trig_nx  = 1'b1;
        cnt_nx   = '0;
        state_nx = S_WAIT;
        if (bus.spi_done) err_nx = 1'b1;
      end
      S_WAIT: begin
        if (bus.spi_done) err_nx = 1'b1;
        if (cnt == WAIT_LAST) state_nx = S_IDLE;
        else                  cnt_nx   = cnt + 8'd1;
      end
      S_DRAIN: if (bus.ss) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.wr_en   = wr.en;
  assign bus.wr_sel  = wr.sel;
  assign bus.wr_id   = wr.id;
  assign bus.wr_data = wr.data;
  assign bus.din_en  = din_en;
  assign bus.trig    = trig;
  assign bus.out_sel = out_sel;
  assign bus.err     = err;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_WAIT) && (cnt == WAIT_LAST);
endmodule

// File: tb/tb_grid_burst_sequencer.sv
// Bench for grid_burst_sequencer: directed frame table, corner sequences and
// random frames, all checked against a frame-level event model.
module tb_grid_burst_sequencer;
  localparam int N  = 8;
  localparam int RW = 4;
  localparam int KWR = 1, KDIN = 2, KTRIG = 3, KDONE = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  logic mon_on = 1'b0;
  int   npass = 0, ntot = 0, nwr = 0;
  logic       m_err = 1'b0;
  logic [2:0] m_out = 3'd0;

  typedef struct {
    int kind; logic [1:0] sel; logic [2:0] id; logic [7:0] data; int cyc;
  } ev_t;
  ev_t expq[$];

  typedef struct {
    logic [7:0] hdr; int npay; logic [7:0] base; logic [7:0] step;
    int abort_at; int exp_wr; logic exp_err; logic [2:0] exp_out;
  } vec_t;
  vec_t tbl[12];

  grid_burst_sequencer_if #(.ID_W(3), .DATA_W(8)) bus ();

  grid_burst_sequencer #(.N_NEURONS(N), .DATA_W(8), .RUN_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input int k, input logic [1:0] s, input logic [2:0] i,
                      input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k; e.sel = s; e.id = i; e.data = d; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic got(input int k, input logic [1:0] s, input logic [2:0] i, input logic [7:0] d);
    ev_t e;
    if (expq.size() == 0) begin
      chk("spurious_event", 32'(k), 32'd0);
    end else begin
      e = expq.pop_front();
      chk("ev_kind", 32'(k), 32'(e.kind));
      chk("ev_cycle", 32'(cyc), 32'(e.cyc));
      if (k == KWR) begin
        chk("wr_sel", 32'(s), 32'(e.sel));
        chk("wr_id", 32'(i), 32'(e.id));
      end
      if (k == KWR || k == KDIN) chk("wr_data", 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    if (bus.wr_en | bus.din_en | bus.trig)
      chk("strobe_excl", 32'(bus.wr_en) + 32'(bus.din_en) + 32'(bus.trig), 32'd1);
    if (bus.wr_en) begin
      nwr++;
      got(KWR, bus.wr_sel, bus.wr_id, bus.wr_data);
    end
    if (bus.din_en) got(KDIN, 2'd0, 3'd0, bus.wr_data);
    if (bus.trig)   got(KTRIG, 2'd0, 3'd0, 8'd0);
    if (bus.done) begin
      got(KDONE, 2'd0, 3'd0, 8'd0);
      chk("done_busy", 32'(bus.busy), 32'd1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input logic ssv, output int c);
    bus.spi_done = 1'b1; bus.spi_input = b; bus.ss = ssv; c = cyc;
    @(posedge clk); #1;
    bus.spi_done = 1'b0; bus.spi_input = 8'($urandom);
  endtask

  task automatic check_zero();
    chk("rst_wr_en", 32'(bus.wr_en), 0);     chk("rst_wr_sel", 32'(bus.wr_sel), 0);
    chk("rst_wr_id", 32'(bus.wr_id), 0);     chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_din_en", 32'(bus.din_en), 0);   chk("rst_trig", 32'(bus.trig), 0);
    chk("rst_out_sel", 32'(bus.out_sel), 0); chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);       chk("rst_err", 32'(bus.err), 0);
  endtask

  task automatic post(input logic e_err, input logic [2:0] e_out);
    chk("busy_after_frame", 32'(bus.busy), 0);
    chk("err", 32'(bus.err), 32'(e_err));
    chk("out_sel", 32'(bus.out_sel), 32'(e_out));
    chk("pending_events", 32'(expq.size()), 0);
  endtask

  // Frame model: what the header and its payload bytes should produce, by rule
  task automatic frame(input logic [7:0] hdr, input int npay, input logic [7:0] base,
                       input logic [7:0] step, input int abort_at);
    logic [1:0] op, fld; logic [2:0] sid; logic ill; int c; logic [7:0] b;
    op = hdr[7:6]; fld = hdr[5:4]; sid = hdr[2:0];
    ill = (op == 2'd3) || (op == 2'd0 && fld == 2'd3);
    bus.ss = 1'b0; idle(1);
    send(hdr, 1'b0, c);
    if (op == 2'd1 || op == 2'd2) m_out = sid;
    if (op == 2'd2 && fld[1]) m_err = 1'b0;
    if (ill) m_err = 1'b1;
    for (int i = 0; i < npay; i++) begin
      idle($urandom_range(0, 2));
      b = base + 8'(i) * step;
      if (i == abort_at) begin
        send(b, 1'b1, c);
        if (!ill) m_err = 1'b1;
        break;
      end
      send(b, 1'b0, c);
      if (!ill) begin
        if (op == 2'd0 && fld != 2'd2 && int'(sid) + i < N)
          push(KWR, fld, 3'(int'(sid) + i), b, c + 1);
        else if (op == 2'd0 && fld == 2'd2 && i == 0)
          push(KWR, 2'd2, 3'd0, b, c + 1);
        else if (op == 2'd1 && i == 0) begin
          push(KDIN, 2'd0, 3'd0, b, c + 1);
          push(KTRIG, 2'd0, 3'd0, 8'd0, c + 2);
          push(KDONE, 2'd0, 3'd0, 8'd0, c + 2 + RW);
        end
      end
    end
    idle(RW + 4); bus.ss = 1'b1; idle(2);
  endtask

  initial begin
    int c, nwr0, npay, ab;
    logic [1:0] op, fld;
    logic [7:0] hdr, b;

    tbl[0]  = '{8'h00, 8, 8'h10, 8'h01, -1, 8, 1'b0, 3'd0};
    tbl[1]  = '{8'h15, 3, 8'h20, 8'h01, -1, 3, 1'b0, 3'd0};
    tbl[2]  = '{8'h43, 1, 8'hA5, 8'h01, -1, 0, 1'b0, 3'd3};
    tbl[3]  = '{8'h02, 6, 8'h30, 8'h01,  1, 1, 1'b1, 3'd3};
    tbl[4]  = '{8'hA0, 0, 8'h00, 8'h00, -1, 0, 1'b0, 3'd0};
    tbl[5]  = '{8'hC0, 2, 8'h00, 8'h41, -1, 0, 1'b1, 3'd0};
    tbl[6]  = '{8'hA6, 0, 8'h00, 8'h00, -1, 0, 1'b0, 3'd6};
    tbl[7]  = '{8'h23, 1, 8'h5C, 8'h01, -1, 1, 1'b0, 3'd6};
    tbl[8]  = '{8'h31, 1, 8'h77, 8'h01, -1, 0, 1'b1, 3'd6};
    tbl[9]  = '{8'h87, 0, 8'h00, 8'h00, -1, 0, 1'b1, 3'd7};
    tbl[10] = '{8'hA1, 0, 8'h00, 8'h00, -1, 0, 1'b0, 3'd1};
    tbl[11] = '{8'h45, 1, 8'h99, 8'h01,  0, 0, 1'b1, 3'd5};

    rst = 1'b1; bus.ss = 1'b1; bus.spi_done = 1'b0; bus.spi_input = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check_zero();
    mon_on = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      nwr0 = nwr;
      frame(tbl[t].hdr, tbl[t].npay, tbl[t].base, tbl[t].step, tbl[t].abort_at);
      chk("tbl_wr_count", 32'(nwr - nwr0), 32'(tbl[t].exp_wr));
      post(tbl[t].exp_err, tbl[t].exp_out);
    end

    // partial bias burst; the byte after id 7 is decoded as a SETOUT header
    bus.ss = 1'b0; idle(1);
    send(8'h15, 1'b0, c);
    for (int i = 0; i < 3; i++) begin
      b = 8'hB0 + 8'(i);
      send(b, 1'b0, c);
      push(KWR, 2'd1, 3'(5 + i), b, c + 1);
    end
    send(8'h82, 1'b0, c); m_out = 3'd2;
    idle(2); bus.ss = 1'b1; idle(2);
    post(1'b1, 3'd2);

    // stray byte during WAIT: dropped, err set, done still on time
    m_err = 1'b0;
    bus.ss = 1'b0; idle(1);
    send(8'hA4, 1'b0, c);
    send(8'h41, 1'b0, c); m_out = 3'd1;
    send(8'h77, 1'b0, c);
    push(KDIN, 2'd0, 3'd0, 8'h77, c + 1);
    push(KTRIG, 2'd0, 3'd0, 8'd0, c + 2);
    push(KDONE, 2'd0, 3'd0, 8'd0, c + 2 + RW);
    idle(1); send(8'h00, 1'b0, c); m_err = 1'b1;
    idle(RW + 4); bus.ss = 1'b1; idle(2);
    post(1'b1, 3'd1);

    // reset held two cycles in the middle of a burst
    bus.ss = 1'b0; idle(1);
    send(8'h00, 1'b0, c);
    for (int i = 0; i < 3; i++) begin
      b = 8'hE0 + 8'(i);
      send(b, 1'b0, c);
      push(KWR, 2'd0, 3'(i), b, c + 1);
    end
    rst = 1'b1; bus.spi_done = 1'b1; bus.spi_input = 8'h99;
    @(posedge clk); #1 bus.spi_done = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    m_err = 1'b0; m_out = 3'd0;
    @(negedge clk); check_zero();
    @(posedge clk); #1;
    idle(4); bus.ss = 1'b1; idle(1);
    post(1'b0, 3'd0);

    for (int r = 0; r < 30; r++) begin
      op  = 2'($urandom_range(0, 3));
      fld = 2'($urandom_range(0, 3));
      hdr = {op, fld, 1'($urandom), 3'($urandom)};
      case (op)
        2'd0:    npay = (fld == 2'd3) ? int'($urandom_range(0, 2)) :
                        (fld == 2'd2) ? 1 : 8 - int'(hdr[2:0]);
        2'd1:    npay = 1;
        2'd2:    npay = 0;
        default: npay = int'($urandom_range(0, 2));
      endcase
      ab = -1;
      if (((op == 2'd0 && fld != 2'd3) || op == 2'd1) && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(0, npay - 1));
      frame(hdr, npay, 8'($urandom), 8'($urandom), ab);
      post(m_err, m_out);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
